state_loader: RTL

STATE_LOADER -- requirements
Module: state_loader

---
 rtl/state_loader_pkg.sv | 16 +
 rtl/state_loader_array.sv | 26 ++
 rtl/state_loader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/state_loader_pkg.sv
// rtl/state_loader_pkg.sv - shared sizes, FSM states and target encodings for the state loader
package state_loader_pkg;

    localparam int WIDTH = 12;
    localparam int DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic TARGET_REG = 1'b0;
    localparam logic TARGET_MEM = 1'b1;

endpackage

// File: rtl/state_loader_array.sv
// rtl/state_loader_array.sv - loader_array: DEPTH x WIDTH preload image with async clear and optional hard-zero entry 0
module loader_array #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic             zero_entry0,
    output logic [WIDTH-1:0] data [DEPTH]
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (we && !(zero_entry0 && widx == '0)) begin
            data[widx] <= wdata;
        end
    end

endmodule

// File: rtl/state_loader.sv
// rtl/state_loader.sv - streams words into register-file / data-memory preload images; LOADER_CHECKSUM_EN adds a running checksum
module state_loader
    import state_loader_pkg::*;
#(
    parameter int WIDTH = state_loader_pkg::WIDTH,
    parameter int DEPTH = state_loader_pkg::DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             target,
    input  logic [4:0]       base,
    input  logic [5:0]       length,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] Registers_entrada [DEPTH],
    output logic [WIDTH-1:0] Memoria_entrada [DEPTH],
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [CW-1:0] count;
    logic          tgt;
    logic          accept;

    // in_ready is a registered copy of (state == LOAD), so accept is only ever true in LOAD
    assign accept = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            count    <= '0;
            tgt      <= TARGET_REG;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= LOAD;
                        tgt      <= target;
                        ptr      <= AW'(base);
                        count    <= (length == '0) ? CW'(DEPTH) : CW'(length);
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ptr   <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;

    // discarded register-0 words still count toward the sum
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (state == IDLE && start) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + in_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

    loader_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regs (
        .clock       (clock),
        .reset       (reset),
        .we          (accept && tgt == TARGET_REG),
        .widx        (ptr),
        .wdata       (in_data),
        .zero_entry0 (1'b1),
        .data        (Registers_entrada)
    );

    loader_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clock       (clock),
        .reset       (reset),
        .we          (accept && tgt == TARGET_MEM),
        .widx        (ptr),
        .wdata       (in_data),
        .zero_entry0 (1'b0),
        .data        (Memoria_entrada)
    );

endmodule
